// File: rtl/cr_lz77_comp_ti_match_sel.sv
// Purpose: capture per-cycle match candidates from the x16 match tile, decode thermometers,
//          select the best length/offset and hand it to the collector through a small FIFO.
// Latency: 3 cycles from ti_vld to sel_vld when the FIFO is empty; backpressure via sel_rdy,
//          early sel_stall hint to the tile, results arriving at a full FIFO are dropped (sel_ovfl).
//
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   ti_vld          candidate set valid this cycle
//   ti_fwd_therm    TRUNC_NUM packed thermometers (candidate i at [i*LONGL +: LONGL])
//   ti_offset       TRUNC_NUM packed offsets (candidate i at [i*LOG_TILE_DEPTH +: LOG_TILE_DEPTH])
//   ti_len4_ind     any bit set: length-4 match at candidate 0's offset
//   ti_len5_6_ind   3'b001 length 5, 3'b011 length 6, other nonzero codes illegal
//   flush           drop pipeline and FIFO contents (sticky flags kept)
//   sel_stall       tile must stop asserting ti_vld
//   sel_vld/sel_rdy result handshake, sel_len/sel_offset from FIFO head
//   sel_ovfl        sticky, a result was dropped
//   sel_err         sticky, illegal thermometer or len5_6 code seen

// Purpose: generic synchronous FIFO with first-word fall-through head.
// Latency: written entry visible at rd_dat the cycle after the write edge.
// Backpressure: writes while full are accepted only together with a read; caller handles drops.
module cr_lz77_comp_ti_match_sel_fifo #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       clr,
   input  logic                       wr_en,
   input  logic [WIDTH-1:0]           wr_dat,
   input  logic                       rd_en,
   output logic [WIDTH-1:0]           rd_dat,
   output logic                       empty,
   output logic                       full,
   output logic [$clog2(DEPTH):0]     cnt
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;
   logic             do_wr;
   logic             do_rd;

   assign empty  = (cnt == '0);
   assign full   = (cnt == (PTR_W+1)'(DEPTH));
   assign do_rd  = rd_en && !empty;
   // A write into a full FIFO is legal only when the head leaves in the same cycle.
   assign do_wr  = wr_en && (!full || do_rd);
   assign rd_dat = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_wr) begin
         mem[wr_ptr] <= wr_dat;
      end
   end

   always_ff @(posedge clk) begin
      if (rst || clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         cnt    <= '0;
      end else begin
         if (do_wr) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (do_rd) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         case ({do_wr, do_rd})
            2'b10:   cnt <= cnt + 1'b1;
            2'b01:   cnt <= cnt - 1'b1;
            default: cnt <= cnt;
         endcase
      end
   end
endmodule

// Purpose: best-match selection for the x16 match tile output.
// Latency: 3 cycles ti_vld -> sel_vld (empty FIFO), one result per cycle sustained.
// Backpressure: sel_rdy holds the FIFO head; sel_stall warns the tile early; overflow drops and flags.
module cr_lz77_comp_ti_match_sel #(
   parameter int TRUNC_NUM      = 3,
   parameter int LOG_TILE_DEPTH = 4,
   parameter int LONGL          = 13,
   parameter int FIFO_DEPTH     = 4
) (
   input  logic                                clk,
   input  logic                                rst,
   input  logic                                ti_vld,
   input  logic [TRUNC_NUM*LONGL-1:0]          ti_fwd_therm,
   input  logic [TRUNC_NUM*LOG_TILE_DEPTH-1:0] ti_offset,
   input  logic [3:0]                          ti_len4_ind,
   input  logic [2:0]                          ti_len5_6_ind,
   input  logic                                flush,
   output logic                                sel_stall,
   output logic                                sel_vld,
   input  logic                                sel_rdy,
   output logic [4:0]                          sel_len,
   output logic [LOG_TILE_DEPTH-1:0]           sel_offset,
   output logic                                sel_ovfl,
   output logic                                sel_err
);
   localparam int PTR_W = $clog2(FIFO_DEPTH);
   localparam int OCC_W = PTR_W + 2;
   localparam int DAT_W = 5 + LOG_TILE_DEPTH;

   // ---------------- Stage 1: input capture ----------------
   logic                                s1_vld;
   logic [TRUNC_NUM*LONGL-1:0]          s1_therm;
   logic [TRUNC_NUM*LOG_TILE_DEPTH-1:0] s1_offset;
   logic [3:0]                          s1_len4;
   logic [2:0]                          s1_len56;

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s1_therm  <= '0;
         s1_offset <= '0;
         s1_len4   <= '0;
         s1_len56  <= '0;
      end else begin
         s1_vld <= ti_vld && !flush;
         if (ti_vld && !flush) begin
            s1_therm  <= ti_fwd_therm;
            s1_offset <= ti_offset;
            s1_len4   <= ti_len4_ind;
            s1_len56  <= ti_len5_6_ind;
         end
      end
   end

   // ---------------- Stage 2: decode and select ----------------
   logic [4:0]                ones;
   logic                      run;
   logic [4:0]                cand_len;
   logic                      any_therm;
   logic                      therm_bad;
   logic                      len56_bad;
   logic [4:0]                short_len;
   logic [4:0]                best_len;
   logic [LOG_TILE_DEPTH-1:0] best_off;

   always_comb begin
      ones      = '0;
      run       = 1'b1;
      cand_len  = '0;
      any_therm = 1'b0;
      therm_bad = 1'b0;
      best_len  = '0;
      best_off  = s1_offset[LOG_TILE_DEPTH-1:0];
      for (int i = 0; i < TRUNC_NUM; i++) begin
         ones = '0;
         run  = 1'b1;
         // Count the run of ones from bit 0; any set bit after the first zero is a broken thermometer.
         for (int k = 0; k < LONGL; k++) begin
            if (s1_therm[i*LONGL + k]) begin
               if (run) begin
                  ones = ones + 5'd1;
               end else begin
                  therm_bad = 1'b1;
               end
            end else begin
               run = 1'b0;
            end
         end
         cand_len = '0;
         if (s1_therm[i*LONGL +: LONGL] != '0) begin
            any_therm = 1'b1;
            cand_len  = 5'd7 + ones;
         end
         // Strict compare keeps the lowest index on ties.
         if (cand_len > best_len) begin
            best_len = cand_len;
            best_off = s1_offset[i*LOG_TILE_DEPTH +: LOG_TILE_DEPTH];
         end
      end

      len56_bad = (s1_len56 != 3'b000) && (s1_len56 != 3'b001) && (s1_len56 != 3'b011);
      if (s1_len56 == 3'b011) begin
         short_len = 5'd6;
      end else if (s1_len56 == 3'b001) begin
         short_len = 5'd5;
      end else if (s1_len4 != 4'h0) begin
         short_len = 5'd4;
      end else begin
         short_len = 5'd0;
      end

      // Short matches only count when no long candidate exists; they always use candidate 0's offset.
      if (!any_therm) begin
         best_len = short_len;
         best_off = s1_offset[LOG_TILE_DEPTH-1:0];
      end
   end

   logic                      s2_vld;
   logic [4:0]                s2_len;
   logic [LOG_TILE_DEPTH-1:0] s2_off;

   always_ff @(posedge clk) begin
      if (rst) begin
         s2_vld  <= 1'b0;
         s2_len  <= '0;
         s2_off  <= '0;
         sel_err <= 1'b0;
      end else begin
         s2_vld <= s1_vld && !flush;
         s2_len <= best_len;
         s2_off <= best_off;
         if (s1_vld && (therm_bad || len56_bad)) begin
            sel_err <= 1'b1;
         end
      end
   end

   // ---------------- Result FIFO ----------------
   logic             fifo_wr;
   logic             fifo_rd;
   logic             fifo_empty;
   logic             fifo_full;
   logic [PTR_W:0]   fifo_cnt;
   logic [DAT_W-1:0] fifo_head;

   assign fifo_wr = s2_vld && !flush;
   assign fifo_rd = sel_vld && sel_rdy && !flush;

   cr_lz77_comp_ti_match_sel_fifo #(
      .WIDTH (DAT_W),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk    (clk),
      .rst    (rst),
      .clr    (flush),
      .wr_en  (fifo_wr),
      .wr_dat ({s2_len, s2_off}),
      .rd_en  (fifo_rd),
      .rd_dat (fifo_head),
      .empty  (fifo_empty),
      .full   (fifo_full),
      .cnt    (fifo_cnt)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         sel_ovfl <= 1'b0;
      end else if (fifo_wr && fifo_full && !fifo_rd) begin
         sel_ovfl <= 1'b1;
      end
   end

   // Head is masked while empty so the outputs read zero out of reset and after a flush.
   assign sel_vld    = !fifo_empty;
   assign sel_len    = fifo_empty ? 5'd0 : fifo_head[DAT_W-1 -: 5];
   assign sel_offset = fifo_empty ? '0 : fifo_head[LOG_TILE_DEPTH-1:0];

   // Occupancy plus in-flight results; one slot of margin covers the tile's one-cycle reaction.
   logic [OCC_W-1:0] occ;
   assign occ       = OCC_W'(fifo_cnt) + OCC_W'(s1_vld) + OCC_W'(s2_vld);
   assign sel_stall = (occ >= OCC_W'(FIFO_DEPTH - 1));
endmodule

// File: tb/tb_cr_lz77_comp_ti_match_sel.sv
module tb_cr_lz77_comp_ti_match_sel;
   localparam int TN = 3;
   localparam int LD = 4;
   localparam int LL = 13;

   logic              clk;
   logic              rst;
   logic              ti_vld;
   logic [TN*LL-1:0]  ti_fwd_therm;
   logic [TN*LD-1:0]  ti_offset;
   logic [3:0]        ti_len4_ind;
   logic [2:0]        ti_len5_6_ind;
   logic              flush;
   logic              sel_stall;
   logic              sel_vld;
   logic              sel_rdy;
   logic [4:0]        sel_len;
   logic [LD-1:0]     sel_offset;
   logic              sel_ovfl;
   logic              sel_err;

   int errors = 0;
   int checks = 0;

   cr_lz77_comp_ti_match_sel #(
      .TRUNC_NUM      (TN),
      .LOG_TILE_DEPTH (LD),
      .LONGL          (LL),
      .FIFO_DEPTH     (4)
   ) dut (
      .clk           (clk),
      .rst           (rst),
      .ti_vld        (ti_vld),
      .ti_fwd_therm  (ti_fwd_therm),
      .ti_offset     (ti_offset),
      .ti_len4_ind   (ti_len4_ind),
      .ti_len5_6_ind (ti_len5_6_ind),
      .flush         (flush),
      .sel_stall     (sel_stall),
      .sel_vld       (sel_vld),
      .sel_rdy       (sel_rdy),
      .sel_len       (sel_len),
      .sel_offset    (sel_offset),
      .sel_ovfl      (sel_ovfl),
      .sel_err       (sel_err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic set_in(input logic [TN*LL-1:0] th, input logic [TN*LD-1:0] of,
                         input logic [3:0] l4, input logic [2:0] l56);
      ti_fwd_therm  = th;
      ti_offset     = of;
      ti_len4_ind   = l4;
      ti_len5_6_ind = l56;
   endtask

   // One-cycle ti_vld pulse followed by two more edges: the result should be at the FIFO head.
   task automatic send3(input logic [TN*LL-1:0] th, input logic [TN*LD-1:0] of,
                        input logic [3:0] l4, input logic [2:0] l56);
      set_in(th, of, l4, l56);
      ti_vld = 1'b1;
      tick();
      ti_vld = 1'b0;
      set_in('0, '0, 4'h0, 3'b000);
      tick();
      tick();
   endtask

   initial begin
      rst    = 1'b1;
      ti_vld = 1'b0;
      flush  = 1'b0;
      sel_rdy = 1'b1;
      set_in('0, '0, 4'h0, 3'b000);
      tick();
      tick();
      chk("rst_vld",   sel_vld,    0);
      chk("rst_stall", sel_stall,  0);
      chk("rst_len",   sel_len,    0);
      chk("rst_off",   sel_offset, 0);
      chk("rst_ovfl",  sel_ovfl,   0);
      chk("rst_err",   sel_err,    0);
      rst = 1'b0;
      tick();

      // Single candidate, latency check.
      set_in({13'h0, 13'h0, 13'h001F}, {4'd0, 4'd0, 4'd9}, 4'h0, 3'b000);
      ti_vld = 1'b1;
      tick();
      ti_vld = 1'b0;
      set_in('0, '0, 4'h0, 3'b000);
      tick();
      chk("lat_not_yet", sel_vld, 0);
      tick();
      chk("single_vld", sel_vld,    1);
      chk("single_len", sel_len,    12);
      chk("single_off", sel_offset, 9);
      chk("single_err", sel_err,    0);
      tick();
      chk("single_popped", sel_vld, 0);

      // Tie between candidates 1 and 2 goes to candidate 1.
      send3({13'h003F, 13'h003F, 13'h0007}, {4'd7, 4'd5, 4'd2}, 4'h0, 3'b000);
      chk("tie_vld", sel_vld,    1);
      chk("tie_len", sel_len,    13);
      chk("tie_off", sel_offset, 5);

      // Short match, length 6.
      send3('0, {4'd1, 4'd2, 4'd3}, 4'hF, 3'b011);
      chk("len6_len", sel_len,    6);
      chk("len6_off", sel_offset, 3);
      chk("len6_err", sel_err,    0);

      // Broken thermometer.
      send3({13'h0, 13'h0, 13'h0005}, {4'd0, 4'd0, 4'd4}, 4'h0, 3'b000);
      chk("bad_therm_len", sel_len,    8);
      chk("bad_therm_off", sel_offset, 4);
      chk("bad_therm_err", sel_err,    1);

      // All-zero candidate set still yields a result.
      send3('0, '0, 4'h0, 3'b000);
      chk("zero_vld", sel_vld, 1);
      chk("zero_len", sel_len, 0);
      tick();

      // Reset with a result in S1: sticky and in-flight state cleared.
      set_in({13'h0, 13'h0, 13'h0001}, {4'd0, 4'd0, 4'd1}, 4'h0, 3'b000);
      ti_vld = 1'b1;
      tick();
      ti_vld = 1'b0;
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_err", sel_err, 0);
      tick();
      tick();
      tick();
      chk("midrst_vld", sel_vld, 0);

      // Illegal len5_6 code falls back to len4.
      send3('0, {4'd0, 4'd0, 4'd3}, 4'hF, 3'b010);
      chk("ill56_len", sel_len,    4);
      chk("ill56_off", sel_offset, 3);
      chk("ill56_err", sel_err,    1);
      tick();

      // Overflow: sel_rdy low, five back-to-back sets, stall ignored.
      sel_rdy = 1'b0;
      for (int j = 0; j < 5; j++) begin
         set_in({13'h0, 13'h0, 13'((1 << (j + 1)) - 1)}, {4'd0, 4'd0, 4'(j + 1)}, 4'h0, 3'b000);
         ti_vld = 1'b1;
         tick();
         chk($sformatf("ovf_stall_%0d", j), sel_stall, (j >= 2) ? 1 : 0);
         chk($sformatf("ovf_flag_%0d", j),  sel_ovfl,  0);
      end
      ti_vld = 1'b0;
      set_in('0, '0, 4'h0, 3'b000);
      tick();
      chk("ovf_flag_4th", sel_ovfl, 0);
      tick();
      chk("ovf_flag_5th", sel_ovfl,  1);
      chk("ovf_stall_full", sel_stall, 1);
      chk("ovf_hold_len", sel_len,   8);
      sel_rdy = 1'b1;
      for (int j = 0; j < 4; j++) begin
         chk($sformatf("drain_vld_%0d", j), sel_vld,    1);
         chk($sformatf("drain_len_%0d", j), sel_len,    8 + j);
         chk($sformatf("drain_off_%0d", j), sel_offset, j + 1);
         tick();
      end
      chk("drain_empty", sel_vld,  0);
      chk("drain_ovfl",  sel_ovfl, 1);

      // Flush with two queued and one in S1; ti_vld during flush is ignored.
      sel_rdy = 1'b0;
      set_in({13'h0, 13'h0, 13'h0001}, {4'd0, 4'd0, 4'd1}, 4'h0, 3'b000);
      ti_vld = 1'b1;
      tick();
      set_in({13'h0, 13'h0, 13'h0001}, {4'd0, 4'd0, 4'd2}, 4'h0, 3'b000);
      tick();
      ti_vld = 1'b0;
      tick();
      tick();
      chk("fl_queued_vld",   sel_vld,   1);
      chk("fl_queued_stall", sel_stall, 0);
      set_in({13'h0, 13'h0, 13'h0001}, {4'd0, 4'd0, 4'd3}, 4'h0, 3'b000);
      ti_vld = 1'b1;
      tick();
      chk("fl_pre_stall", sel_stall, 1);
      set_in({13'h0, 13'h0, 13'h0001}, {4'd0, 4'd0, 4'd6}, 4'h0, 3'b000);
      flush = 1'b1;
      tick();
      flush  = 1'b0;
      ti_vld = 1'b0;
      chk("fl_vld",   sel_vld,   0);
      chk("fl_stall", sel_stall, 0);
      for (int j = 0; j < 4; j++) begin
         tick();
         chk($sformatf("fl_quiet_%0d", j), sel_vld, 0);
      end
      chk("fl_ovfl_kept", sel_ovfl, 1);

      sel_rdy = 1'b1;
      send3({13'h0, 13'h0, 13'h0003}, {4'd0, 4'd0, 4'd7}, 4'h0, 3'b000);
      chk("post_fl_vld", sel_vld,    1);
      chk("post_fl_len", sel_len,    9);
      chk("post_fl_off", sel_offset, 7);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
